// File: rtl/gear_box_pkg.sv
// Shared sizing for the 13-byte to 8-word reverse gearbox.
// Counter widths are derived here so the bank and top agree.
package gear_box_pkg;

    localparam int IN_W            = 8;
    localparam int OUT_W           = 13;
    localparam int BYTES_PER_FRAME = 13;
    localparam int WORDS_PER_FRAME = 8;
    localparam int BANK_W          = IN_W * BYTES_PER_FRAME;
    localparam int BCNT_W          = 4;
    localparam int WCNT_W          = 3;

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_FRAME - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_FRAME - 1);

    typedef logic [IN_W-1:0]  byte_t;
    typedef logic [OUT_W-1:0] word_t;

endpackage

// File: rtl/gear_unbox_bank.sv
// One 104-bit frame bank: byte-indexed writes, 13-bit word-indexed reads.
// A clear wipes the whole bank so short frames read back zero-padded.
module gear_unbox_bank
    import gear_box_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [BCNT_W-1:0] wr_idx,
    input  logic [IN_W-1:0]   wr_data,
    input  logic              clr,
    input  logic [WCNT_W-1:0] rd_idx,
    output logic [OUT_W-1:0]  rd_data
);

    logic [BANK_W-1:0] mem_q;
    logic [BANK_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            mem_d = '0;
        end else if (wr_en) begin
            for (int k = 0; k < BYTES_PER_FRAME; k++) begin
                if (wr_idx == BCNT_W'(k)) begin
                    mem_d[k*IN_W +: IN_W] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < WORDS_PER_FRAME; j++) begin
            if (rd_idx == WCNT_W'(j)) begin
                rd_data = mem_q[j*OUT_W +: OUT_W];
            end
        end
    end

endmodule

// File: rtl/buffered_gear_unbox.sv
// Ping-pong reverse gearbox: 13 input bytes become 8 output words of 13 bits.
// Define GEAR_UNBOX_FLUSH_EN to add in_flush for zero-padded partial frames.
module buffered_gear_unbox
    import gear_box_pkg::*;
(
    input  logic             clk_250,
    input  logic             sys_reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef GEAR_UNBOX_FLUSH_EN
    input  logic             in_flush,
`endif
    output logic             out_sof
);

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;

    logic              in_fire;
    logic              out_fire;
    logic              flush_go;
    logic              wr_close;
    logic              rd_release;
    logic [1:0]        bank_wr_en;
    logic [1:0]        bank_clr;
    logic [OUT_W-1:0]  rd_word [2];

`ifdef GEAR_UNBOX_FLUSH_EN
    assign flush_go = in_flush & ~full_q[wr_bank_q] & (byte_cnt_q != '0);
`else
    assign flush_go = 1'b0;
`endif

    always_comb begin
        in_ready   = ~full_q[wr_bank_q] & ~sys_reset;
        out_valid  = full_q[rd_bank_q] & ~sys_reset;
        out_sof    = out_valid & (word_cnt_q == '0);
        out_data   = out_valid ? rd_word[rd_bank_q] : '0;
        in_fire    = in_valid & in_ready;
        out_fire   = out_valid & out_ready;
        wr_close   = (in_fire & (byte_cnt_q == LAST_BYTE)) | flush_go;
        rd_release = out_fire & (word_cnt_q == LAST_WORD);
    end

    // Write and read sides always own different banks, so both may act at once.
    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        if (wr_close) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            byte_cnt_d        = '0;
        end else if (in_fire) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            word_cnt_d        = '0;
        end else if (out_fire) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_250) begin
        if (sys_reset) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        bank_wr_en            = '0;
        bank_wr_en[wr_bank_q] = in_fire;
        bank_clr              = '0;
`ifdef GEAR_UNBOX_FLUSH_EN
        bank_clr[rd_bank_q] = rd_release;
        if (sys_reset) begin
            bank_clr = '1;
        end
`endif
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        gear_unbox_bank u_bank (
            .clk     (clk_250),
            .wr_en   (bank_wr_en[b]),
            .wr_idx  (byte_cnt_q),
            .wr_data (in_data),
            .clr     (bank_clr[b]),
            .rd_idx  (word_cnt_q),
            .rd_data (rd_word[b])
        );
    end

endmodule

// File: tb/tb_buffered_gear_unbox.sv
// Scoreboard bench for buffered_gear_unbox.
// Expected words are queued as frames are driven and checked on each output beat.
module tb_buffered_gear_unbox;

    logic        clk_250 = 1'b0;
    logic        sys_reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
`ifdef GEAR_UNBOX_FLUSH_EN
    logic        in_flush;
`endif

    always #2 clk_250 = ~clk_250;

    buffered_gear_unbox dut (
        .clk_250   (clk_250),
        .sys_reset (sys_reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef GEAR_UNBOX_FLUSH_EN
        .in_flush  (in_flush),
`endif
        .out_sof   (out_sof)
    );

    typedef logic [7:0]  frame_t [13];
    typedef logic [12:0] words_t [8];
    typedef struct packed {
        logic [12:0] d;
        logic        sof;
    } exp_t;

    exp_t   sb[$];
    exp_t   cur;
    int     total = 0;
    int     bad = 0;
    int     words_seen = 0;
    bit     rand_rdy = 1'b0;
    frame_t f;
    words_t w;
    longint t0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input frame_t fr, output words_t wo);
        logic [103:0] v;
        for (int k = 0; k < 13; k++) v[8*k +: 8] = fr[k];
        for (int j = 0; j < 8; j++) wo[j] = v[13*j +: 13];
    endtask

    task automatic push_words(input words_t wi);
        exp_t e;
        for (int j = 0; j < 8; j++) begin
            e.d   = wi[j];
            e.sof = (j == 0);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk_250);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic put_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk_250);
        while (!in_ready && t < 300) begin
            @(negedge clk_250);
            t++;
        end
        if (!in_ready) check("in_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t fr, input words_t wi);
        push_words(wi);
        for (int k = 0; k < 13; k++) put_byte(fr[k]);
    endtask

    task automatic rand_frame(output frame_t fr);
        for (int k = 0; k < 13; k++) fr[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 600) begin
            tick();
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        sys_reset = 1'b1;
        repeat (n) begin
            @(negedge clk_250);
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_ready", 32'(in_ready), 32'd0);
            check("rst_data", 32'(out_data), 32'd0);
            check("rst_sof", 32'(out_sof), 32'd0);
            tick();
        end
        sys_reset = 1'b0;
        sb.delete();
        words_seen = 0;
    endtask

    always @(negedge clk_250) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("extra_word", 32'(out_valid), 32'd0);
            end else begin
                cur = sb.pop_front();
                check("word", 32'(out_data), 32'(cur.d));
                check("sof", 32'(out_sof), 32'(cur.sof));
                words_seen++;
            end
        end else if (!out_valid) begin
            check("idle_zero", 32'(out_data), 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_reset = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef GEAR_UNBOX_FLUSH_EN
        in_flush  = 1'b0;
`endif
        do_reset(3);
        @(negedge clk_250);
        check("init_ready", 32'(in_ready), 32'd1);
        check("init_valid", 32'(out_valid), 32'd0);
        tick();

        f = '{0: 8'h00, 1: 8'h01, 2: 8'h02, 3: 8'h03, default: 8'h00};
        w = '{0: 13'h0100, 1: 13'h1810, default: 13'h0000};
        send_frame(f, w);
        wait_drain();

        f = '{default: 8'hFF};
        w = '{default: 13'h1FFF};
        push_words(w);
        for (int k = 0; k < 12; k++) put_byte(f[k]);
        check("early_valid", 32'(out_valid), 32'd0);
        put_byte(f[12]);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_sof", 32'(out_sof), 32'd1);
        wait_drain();

        f = '{0: 8'h01, 12: 8'h80, default: 8'h00};
        w = '{0: 13'h0001, 7: 13'h1000, default: 13'h0000};
        send_frame(f, w);
        wait_drain();

        out_ready  = 1'b0;
        words_seen = 0;
        for (int n = 0; n < 2; n++) begin
            rand_frame(f);
            model(f, w);
            send_frame(f, w);
        end
        @(negedge clk_250);
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h5C;
        repeat (3) @(negedge clk_250);
        check("bp_hold", 32'(in_ready), 32'd0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        begin
            int t = 0;
            while (words_seen < 8 && t < 100) begin
                @(negedge clk_250);
                #1;
                t++;
            end
        end
        check("bp_words8", 32'(words_seen), 32'd8);
        check("bp_still", 32'(in_ready), 32'd0);
        @(negedge clk_250);
        #1;
        check("bp_resume", 32'(in_ready), 32'd1);
        wait_drain();
        check("bp_total", 32'(words_seen), 32'd16);
        rand_frame(f);
        model(f, w);
        send_frame(f, w);
        wait_drain();

        t0 = $time;
        for (int n = 0; n < 3; n++) begin
            rand_frame(f);
            model(f, w);
            send_frame(f, w);
        end
        check("rate", 32'(($time - t0) / 4), 32'd39);
        wait_drain();

        out_ready = 1'b0;
        rand_frame(f);
        model(f, w);
        send_frame(f, w);
        for (int k = 0; k < 5; k++) put_byte(8'(8'hA0 + k));
        do_reset(2);
        out_ready = 1'b1;
        @(negedge clk_250);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        tick();
        f = '{0: 8'h11, 1: 8'h22, 2: 8'h33, 3: 8'h44, 4: 8'h55, 5: 8'h66,
              6: 8'h77, 7: 8'h88, 8: 8'h99, 9: 8'hAA, 10: 8'hBB,
              11: 8'hCC, 12: 8'hDD};
        model(f, w);
        send_frame(f, w);
        wait_drain();
        check("post_rst_words", 32'(words_seen), 32'd8);

        rand_rdy = 1'b1;
        for (int n = 0; n < 4; n++) begin
            rand_frame(f);
            model(f, w);
            send_frame(f, w);
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

`ifdef GEAR_UNBOX_FLUSH_EN
        w = '{0: 13'h1BAA, 1: 13'h0665, default: 13'h0000};
        push_words(w);
        put_byte(8'hAA);
        put_byte(8'hBB);
        put_byte(8'hCC);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd1);
        wait_drain();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        @(negedge clk_250);
        check("flush_noop", 32'(out_valid), 32'd0);
        tick();
        w = '{0: 13'h005A, default: 13'h0000};
        push_words(w);
        put_byte(8'h5A);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        wait_drain();
`endif

        repeat (4) tick();
        check("end_empty", 32'(out_valid), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
